apb0_ahb_bridge: RTL and testbench
==================================

// Module: apb0_ahb_bridge
// PURPOSE
// - AHB-Lite slave to APB master bridge; sole driver of the APB0 leaf-mux root port (i_root_*).
// - Converts each AHB read/write into one APB SETUP/ACCESS transfer; one transfer outstanding.
// - Maps APB PSLVERR and no-response timeouts to a two-cycle AHB ERROR response.
// PARAMETERS
// - TIMEOUT_CYCLES  default 1024  ACCESS cycles with PREADY low before abort; 0 disables timeout
// - TO_CNT_W        default 11    counter width; must satisfy 2**TO_CNT_W > TIMEOUT_CYCLES
// PORTS
// - i_hclk           in   1   clock; AHB and APB share this clock
// - i_hrst           in   1   reset, asynchronous, active-high
// - i_hsel           in   1   AHB slave select
// - i_haddr          in   32  AHB address
// - i_htrans         in   2   AHB transfer type; bit1=1 (NONSEQ/SEQ) is a valid transfer
// - i_hwrite         in   1   1=write
// - i_hsize          in   3   0=byte, 1=half, 2=word; >2 is illegal
// - i_hprot          in   4   AHB protection
// - i_hwdata         in   32  AHB write data (data phase)
// - i_hready         in   1   AHB bus ready (address-phase qualifier)
// - o_hreadyout      out  1   slave ready
// - o_hresp          out  2   0=OKAY, 1=ERROR
// - o_hrdata         out  32  read data
// - o_root_psel      out  1   APB select
// - o_root_paddr     out  32  APB address
// - o_root_penable   out  1   APB enable
// - o_root_pwdata    out  32  APB write data
// - o_root_pstrb     out  4   APB byte strobes
// - o_root_pwrite    out  1   APB direction
// - o_root_pprot     out  3   APB protection
// - i_root_pready    in   1   APB ready from the leaf mux
// - i_root_pslverr   in   1   APB error from the leaf mux
// - i_root_prdata    in   32  APB read data from the leaf mux
// BEHAVIOUR
// - Accept: i_hsel & i_htrans[1] & i_hready, in state IDLE, DONE or ERR2.
//   On accept, register haddr, hwrite, hsize, hprot.
// - States (registered, one-hot or encoded):
//   IDLE   -> SETUP on accept with hsize<=2; -> ERR1 on accept with hsize>2 (no APB access).
//   SETUP  psel=1, penable=0, hreadyout=0. Always -> ACCESS.
//   ACCESS psel=1, penable=1, hreadyout=0.
//          pready & ~pslverr -> DONE; pready & pslverr -> ERR1.
//          ~pready & timeout reached -> ERR1 (psel and penable drop in the next cycle).
//   DONE   hreadyout=1, hresp=OKAY; hrdata = prdata registered on the ACCESS completion.
//          -> SETUP/ERR1 on accept, else IDLE.
//   ERR1   hreadyout=0, hresp=ERROR. Always -> ERR2.
//   ERR2   hreadyout=1, hresp=ERROR. -> SETUP/ERR1 on accept, else IDLE.
// - Latency: address phase in cycle N, SETUP in N+1, ACCESS in N+2; zero-wait APB gives
//   DONE (hreadyout=1) in N+3. Each PREADY-low cycle adds one.
// - paddr, pwrite and pprot are held constant from SETUP through the end of ACCESS.
// - pwdata: driven from i_hwdata during SETUP, captured at the end of SETUP, held from the
//   register during ACCESS. Reads drive pwdata=0 and pstrb=0.
// - pstrb (writes only):
//   byte: 4'b0001<<haddr[1:0]; half: 4'b0011<<{haddr[1],1'b0}; word: 4'hF.
//   Unaligned low address bits are ignored.
// - pprot = {~hprot[0], 1'b0, hprot[1]} (instruction, secure, privileged).
// - Timeout counter: clears on SETUP, increments each ACCESS cycle with pready low, and
//   aborts when it equals TIMEOUT_CYCLES. No increment or abort when TIMEOUT_CYCLES==0.
// - Address not decoded by the leaf mux: the mux returns pready=pslverr=1, giving a normal
//   ERR1/ERR2 response.
// - o_hrdata keeps its last value outside DONE; it is not cleared on error.
// - Accepts with htrans IDLE/BUSY, or with i_hsel=0, are ignored and keep OKAY/ready.
// - Reset (any cycle, including mid-ACCESS), asynchronous:
//   state=IDLE, hreadyout=1, hresp=0, hrdata=0, psel=0, penable=0, paddr/pwdata/pstrb/
//   pwrite/pprot=0, counter=0.
// TESTING
// - Word write 0x4001_0004 = 0xA5A5_5A5A, pready=1 -> SETUP at N+1, ACCESS at N+2,
//   pstrb=F, pwdata held, hreadyout=1 OKAY at N+3.
// - Byte write to ...0x3 -> pstrb=4'b1000; half write to ...0x2 -> pstrb=4'b1100;
//   read -> pstrb=0, pwrite=0.
// - Read, pready low for 3 ACCESS cycles, prdata=0x1234_5678 -> DONE at N+6 with
//   hrdata=0x1234_5678, OKAY.
// - pslverr=1 with pready -> ERR1 (hreadyout=0, ERROR) then ERR2 (hreadyout=1, ERROR);
//   hsize=3 -> same response, psel never asserts.
// - TIMEOUT_CYCLES=4, pready stuck low -> abort after 4 ACCESS cycles, psel drops,
//   ERROR pair, next transfer completes normally.
// - Back-to-back: accept issued in DONE/ERR2 -> next SETUP in the following cycle;
//   i_hrst pulse mid-ACCESS -> psel/penable low immediately, hreadyout=1.

Source files
------------

// File: rtl/apb0_ahb_bridge.sv
// AHB-Lite slave to APB master bridge driving the APB0 leaf-mux root port.
// One APB SETUP/ACCESS transfer per AHB transfer, one outstanding. PSLVERR,
// illegal sizes and PREADY timeouts all end in a two-cycle AHB ERROR response.
module apb0_ahb_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,  // 0 disables the timeout
    parameter int TO_CNT_W       = 11     // 2**TO_CNT_W > TIMEOUT_CYCLES
) (
    input  logic        i_hclk,
    input  logic        i_hrst,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [3:0]  i_hprot,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic        o_hreadyout,
    output logic [1:0]  o_hresp,
    output logic [31:0] o_hrdata,
    output logic        o_root_psel,
    output logic [31:0] o_root_paddr,
    output logic        o_root_penable,
    output logic [31:0] o_root_pwdata,
    output logic [3:0]  o_root_pstrb,
    output logic        o_root_pwrite,
    output logic [2:0]  o_root_pprot,
    input  logic        i_root_pready,
    input  logic        i_root_pslverr,
    input  logic [31:0] i_root_prdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, pwdata_q, hrdata_q;
    logic                write_q;
    logic [3:0]          strb_q, strb_d;
    logic [2:0]          prot_q;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                accept, size_ok, to_hit, access_ok;

    // hprot[3:2] (bufferable/cacheable) and htrans[0] (SEQ vs NONSEQ) do not
    // matter to a single APB transfer.
    logic unused_ok;
    assign unused_ok = &{1'b0, i_hprot[3:2], i_htrans[0]};

    // A new address phase is only taken when no APB transfer is in flight.
    assign accept    = i_hsel & i_htrans[1] & i_hready &
                       ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR2));
    assign size_ok   = (i_hsize <= 3'd2);
    assign access_ok = (state_q == S_ACCESS) & i_root_pready & ~i_root_pslverr;
    // Abort on the cycle whose increment would make the counter reach the limit,
    // so ACCESS lasts exactly TIMEOUT_CYCLES cycles with PREADY low.
    assign to_hit    = (TIMEOUT_CYCLES != 0) &&
                       ((cnt_q + 1'b1) == TO_CNT_W'(TIMEOUT_CYCLES));

    // Byte strobes for the incoming address phase; reads carry no strobes.
    always_comb begin
        strb_d = 4'h0;
        case (i_hsize)
            3'd0:    strb_d = 4'b0001 << i_haddr[1:0];
            3'd1:    strb_d = 4'b0011 << {i_haddr[1], 1'b0};
            default: strb_d = 4'hF;
        endcase
        if (!i_hwrite) strb_d = 4'h0;
    end

    // Next-state and timeout counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = '0;
            end
            S_ACCESS: begin
                if (i_root_pready)
                    state_d = i_root_pslverr ? S_ERR1 : S_DONE;
                else if (to_hit)
                    state_d = S_ERR1;
                if (!i_root_pready && (TIMEOUT_CYCLES != 0))
                    cnt_d = cnt_q + 1'b1;
            end
            S_ERR1:  state_d = S_ERR2;
            default: begin  // IDLE, DONE, ERR2
                if (accept) state_d = size_ok ? S_SETUP : S_ERR1;
                else        state_d = S_IDLE;
            end
        endcase
    end

    // State register and counter.
    always_ff @(posedge i_hclk or posedge i_hrst) begin
        if (i_hrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address-phase capture, write-data capture at end of SETUP, read-data capture on success.
    always_ff @(posedge i_hclk or posedge i_hrst) begin
        if (i_hrst) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            prot_q   <= '0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= i_haddr;
                write_q <= i_hwrite;
                strb_q  <= strb_d;
                prot_q  <= {~i_hprot[0], 1'b0, i_hprot[1]};
            end
            if (state_q == S_SETUP)
                pwdata_q <= write_q ? i_hwdata : 32'h0;
            if (access_ok)
                hrdata_q <= i_root_prdata;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        o_root_psel    = (state_q == S_SETUP) | (state_q == S_ACCESS);
        o_root_penable = (state_q == S_ACCESS);
        o_hreadyout    = ~((state_q == S_SETUP) | (state_q == S_ACCESS) | (state_q == S_ERR1));
        o_hresp        = ((state_q == S_ERR1) | (state_q == S_ERR2)) ? 2'b01 : 2'b00;
        o_hrdata       = hrdata_q;
        o_root_paddr   = addr_q;
        o_root_pwrite  = write_q;
        o_root_pprot   = prot_q;
        o_root_pstrb   = strb_q;
        // hwdata is only valid in the AHB data phase (SETUP); ACCESS uses the captured copy.
        o_root_pwdata  = (state_q == S_SETUP) ? (write_q ? i_hwdata : 32'h0) : pwdata_q;
    end

endmodule

// File: tb/tb_apb0_ahb_bridge.sv
// Self-checking bench for apb0_ahb_bridge (timeout set to 4 cycles).
module tb_apb0_ahb_bridge;

    localparam int TB_TO = 4;

    logic        hclk = 1'b0, hrst = 1'b1;
    logic        hsel = 0, hwrite = 0, hready = 1;
    logic [31:0] haddr = 0, hwdata = 0;
    logic [1:0]  htrans = 0;
    logic [2:0]  hsize = 0;
    logic [3:0]  hprot = 0;
    logic        hreadyout, psel, penable, pwrite;
    logic [1:0]  hresp;
    logic [31:0] hrdata, paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready = 0, pslverr = 0;
    logic [31:0] prdata = 0;

    apb0_ahb_bridge #(.TIMEOUT_CYCLES(TB_TO), .TO_CNT_W(3)) dut (
        .i_hclk(hclk), .i_hrst(hrst), .i_hsel(hsel), .i_haddr(haddr), .i_htrans(htrans),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hprot(hprot), .i_hwdata(hwdata), .i_hready(hready),
        .o_hreadyout(hreadyout), .o_hresp(hresp), .o_hrdata(hrdata),
        .o_root_psel(psel), .o_root_paddr(paddr), .o_root_penable(penable),
        .o_root_pwdata(pwdata), .o_root_pstrb(pstrb), .o_root_pwrite(pwrite),
        .o_root_pprot(pprot), .i_root_pready(pready), .i_root_pslverr(pslverr),
        .i_root_prdata(prdata)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [7:0]  setup_at;   // cycle after address phase where SETUP is seen
        logic [7:0]  access_n;   // number of ACCESS cycles
        logic [7:0]  done_at;    // cycle where hreadyout returns high
        logic [31:0] paddr;
        logic [3:0]  strb;
        logic [31:0] pwdata;
        logic        pwrite;
        logic [2:0]  pprot;
        logic        held_bad;   // APB fields changed during ACCESS
        logic        err1;       // hreadyout low + ERROR seen with psel low
        logic [1:0]  hresp;
        logic [31:0] hrdata;
    } rec_t;

    rec_t        sb[$];
    logic [34:0] bq[$];
    logic [31:0] mdl_hrdata = 0;
    int          n_pass = 0, n_chk = 0;

    function automatic logic [3:0] exp_strb(logic [31:0] a, logic w, logic [2:0] sz);
        if (!w) return 4'h0;
        case (sz)
            3'd0:    return 4'b0001 << a[1:0];
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    // Reference model of one transfer; nwait<0 means PREADY never rises.
    function automatic rec_t mk_exp(logic [31:0] a, logic w, logic [2:0] sz, logic [3:0] pr,
                                    logic [31:0] wd, int nwait, logic perr, logic [31:0] rd);
        rec_t e;
        e = '0;
        if (sz > 3'd2) begin
            e.done_at = 8'd2; e.err1 = 1'b1; e.hresp = 2'b01; e.hrdata = mdl_hrdata;
            return e;
        end
        e.setup_at = 8'd1;
        e.paddr    = a;
        e.strb     = exp_strb(a, w, sz);
        e.pwdata   = w ? wd : 32'h0;
        e.pwrite   = w;
        e.pprot    = {~pr[0], 1'b0, pr[1]};
        if (nwait < 0) begin
            e.access_n = 8'(TB_TO); e.done_at = 8'(TB_TO + 3); e.err1 = 1'b1; e.hresp = 2'b01;
        end else if (perr) begin
            e.access_n = 8'(nwait + 1); e.done_at = 8'(nwait + 4); e.err1 = 1'b1; e.hresp = 2'b01;
        end else begin
            e.access_n = 8'(nwait + 1); e.done_at = 8'(nwait + 3);
            mdl_hrdata = rd;
        end
        e.hrdata = mdl_hrdata;
        return e;
    endfunction

    // Drives one AHB transfer, acts as the APB completer, records what the DUT did.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [3:0] pr, input logic [31:0] wd, input int nwait,
                        input logic perr, input logic [31:0] rd, output rec_t o);
        int nacc;
        o = '0; nacc = 0;
        @(posedge hclk); #1;
        hsel = 1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; hprot = pr; hready = 1;
        @(posedge hclk); #1;
        hsel = 0; htrans = 2'b00; hwdata = wd;
        for (int c = 1; c <= 64; c++) begin
            @(negedge hclk);
            if (psel && !penable) begin
                o.setup_at = 8'(c); o.paddr = paddr; o.strb = pstrb;
                o.pwdata = pwdata; o.pwrite = pwrite; o.pprot = pprot;
            end
            if (psel && penable) begin
                nacc++;
                if (pwdata !== o.pwdata || paddr !== o.paddr || pwrite !== o.pwrite ||
                    pstrb !== o.strb || pprot !== o.pprot) o.held_bad = 1'b1;
                hwdata  = ~wd;
                pready  = (nwait >= 0) && (nacc > nwait);
                pslverr = pready & perr;
                prdata  = rd;
            end else begin
                pready = 0; pslverr = 0; prdata = 32'hDEAD_BEEF;
            end
            if (!hreadyout && hresp == 2'b01 && !psel) o.err1 = 1'b1;
            if (hreadyout) begin
                o.done_at = 8'(c); o.hresp = hresp; o.hrdata = hrdata;
                break;
            end
        end
        o.access_n = 8'(nacc);
        pready = 0; pslverr = 0;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel = 1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; hprot = 4'h0; hready = 1;
    endtask

    task automatic test_reset();
        @(negedge hclk);
        n_chk++;
        if ({hreadyout, hresp, hrdata} !== {1'b1, 2'b00, 32'h0})
            $display("FAIL reset_ahb got=%h exp=%h", {hreadyout, hresp, hrdata}, {1'b1, 34'h0});
        else n_pass++;
        n_chk++;
        if ({psel, penable, paddr, pwdata, pstrb, pwrite, pprot} !== 73'h0)
            $display("FAIL reset_apb got=%h exp=0", {psel, penable, paddr, pwdata, pstrb, pwrite, pprot});
        else n_pass++;
        @(posedge hclk); #1; hrst = 0;
    endtask

    task automatic test_ignored();
        int bad;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
            hsel = (i != 0); hready = (i != 2); htrans = (i == 1) ? 2'b01 : 2'b10;
            haddr = 32'h4000_0F00; hsize = 3'd2;
            @(negedge hclk);
            if (psel || !hreadyout || hresp !== 2'b00) bad++;
        end
        @(posedge hclk); #1; hsel = 0; htrans = 0; hready = 1;
        @(negedge hclk);
        if (psel || !hreadyout || hresp !== 2'b00) bad++;
        n_chk++;
        if (bad != 0) $display("FAIL ignored_accepts bad_cycles=%0d exp=0", bad);
        else n_pass++;
    endtask

    task automatic test_word_write();
        rec_t o, e;
        sb.push_back(mk_exp(32'h4001_0004, 1'b1, 3'd2, 4'b0011, 32'hA5A5_5A5A, 0, 1'b0, 32'h77));
        xfer(32'h4001_0004, 1'b1, 3'd2, 4'b0011, 32'hA5A5_5A5A, 0, 1'b0, 32'h77, o);
        e = sb.pop_front();
        n_chk++;
        if (o !== e) $display("FAIL word_write got=%h exp=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_strobes();
        logic [31:0] ta [5] = '{32'h4000_0013, 32'h4000_0022, 32'h4000_0008, 32'h4000_0031, 32'h4000_0003};
        logic        tw [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  ts [5] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
        int          tn [5] = '{0, 2, 0, 1, 0};
        rec_t o, e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk_exp(ta[i], tw[i], ts[i], 4'(i), 32'hC0DE_0000 + 32'(i), tn[i], 1'b0, 32'h100 + 32'(i)));
            xfer(ta[i], tw[i], ts[i], 4'(i), 32'hC0DE_0000 + 32'(i), tn[i], 1'b0, 32'h100 + 32'(i), o);
            e = sb.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL strobes[%0d] got=%h exp=%h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_wait_read();
        rec_t o, e;
        sb.push_back(mk_exp(32'h4000_0040, 1'b0, 3'd2, 4'b0010, 32'hFFFF_FFFF, 3, 1'b0, 32'h1234_5678));
        xfer(32'h4000_0040, 1'b0, 3'd2, 4'b0010, 32'hFFFF_FFFF, 3, 1'b0, 32'h1234_5678, o);
        e = sb.pop_front();
        n_chk++;
        if (o !== e) $display("FAIL wait_read got=%h exp=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_errors();
        rec_t o, e;
        sb.push_back(mk_exp(32'h4000_0050, 1'b0, 3'd2, 4'h0, 32'h0, 1, 1'b1, 32'h9999_9999));
        xfer(32'h4000_0050, 1'b0, 3'd2, 4'h0, 32'h0, 1, 1'b1, 32'h9999_9999, o);
        e = sb.pop_front();
        n_chk++;
        if (o !== e) $display("FAIL pslverr got=%h exp=%h", o, e);
        else n_pass++;
        sb.push_back(mk_exp(32'h4000_0060, 1'b1, 3'd3, 4'h1, 32'h1, 0, 1'b0, 32'h0));
        xfer(32'h4000_0060, 1'b1, 3'd3, 4'h1, 32'h1, 0, 1'b0, 32'h0, o);
        e = sb.pop_front();
        n_chk++;
        if (o !== e) $display("FAIL bad_hsize got=%h exp=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_timeout();
        rec_t o, e;
        sb.push_back(mk_exp(32'h4000_0070, 1'b1, 3'd2, 4'h2, 32'h5A5A_0000, -1, 1'b0, 32'h0));
        xfer(32'h4000_0070, 1'b1, 3'd2, 4'h2, 32'h5A5A_0000, -1, 1'b0, 32'h0, o);
        e = sb.pop_front();
        n_chk++;
        if (o !== e) $display("FAIL timeout got=%h exp=%h", o, e);
        else n_pass++;
        sb.push_back(mk_exp(32'h4000_0500, 1'b0, 3'd2, 4'h0, 32'h0, 0, 1'b0, 32'h5555_AAAA));
        xfer(32'h4000_0500, 1'b0, 3'd2, 4'h0, 32'h0, 0, 1'b0, 32'h5555_AAAA, o);
        e = sb.pop_front();
        n_chk++;
        if (o !== e) $display("FAIL after_timeout got=%h exp=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [34:0] eb;
        // A: write OK, B issued in DONE, errors; C issued in ERR2, completes OK.
        @(posedge hclk); #1; drive_addr(32'h4000_0100, 1'b1, 3'd2);
        bq.push_back({1'b1, 2'b00, 32'h0000_00AA});
        @(posedge hclk); #1; hsel = 0; htrans = 0; hwdata = 32'h1111_1111;
        @(posedge hclk); #1; pready = 1; prdata = 32'h0000_00AA;
        @(posedge hclk); #1; pready = 0; drive_addr(32'h4000_0200, 1'b0, 3'd2);
        bq.push_back({1'b1, 2'b01, 32'h0000_00AA});
        @(negedge hclk);
        eb = bq.pop_front();
        n_chk++;
        if ({hreadyout, hresp, hrdata} !== eb) $display("FAIL b2b_done got=%h exp=%h", {hreadyout, hresp, hrdata}, eb);
        else n_pass++;
        @(posedge hclk); #1; hsel = 0; htrans = 0;
        @(negedge hclk);
        n_chk++;
        if ({psel, penable, paddr, pwrite} !== {1'b1, 1'b0, 32'h4000_0200, 1'b0})
            $display("FAIL b2b_setup_after_done got=%h exp=%h", {psel, penable, paddr, pwrite}, {2'b10, 32'h4000_0200, 1'b0});
        else n_pass++;
        @(posedge hclk); #1; pready = 1; pslverr = 1;
        @(posedge hclk); #1; pready = 0; pslverr = 0;
        @(negedge hclk);
        n_chk++;
        if ({hreadyout, hresp, psel} !== {1'b0, 2'b01, 1'b0})
            $display("FAIL b2b_err1 got=%b exp=%b", {hreadyout, hresp, psel}, 4'b0010);
        else n_pass++;
        @(posedge hclk); #1; drive_addr(32'h4000_0303, 1'b1, 3'd0);
        bq.push_back({1'b1, 2'b00, 32'h0000_00CC});
        @(negedge hclk);
        eb = bq.pop_front();
        n_chk++;
        if ({hreadyout, hresp, hrdata} !== eb) $display("FAIL b2b_err2 got=%h exp=%h", {hreadyout, hresp, hrdata}, eb);
        else n_pass++;
        @(posedge hclk); #1; hsel = 0; htrans = 0; hwdata = 32'hCC00_0000;
        @(negedge hclk);
        n_chk++;
        if ({psel, penable, paddr, pstrb, pwdata} !== {2'b10, 32'h4000_0303, 4'b1000, 32'hCC00_0000})
            $display("FAIL b2b_setup_after_err got=%h exp=%h", {psel, penable, paddr, pstrb, pwdata}, {2'b10, 32'h4000_0303, 4'b1000, 32'hCC00_0000});
        else n_pass++;
        @(posedge hclk); #1; pready = 1; prdata = 32'h0000_00CC;
        @(posedge hclk); #1; pready = 0;
        @(negedge hclk);
        eb = bq.pop_front();
        n_chk++;
        if ({hreadyout, hresp, hrdata} !== eb) $display("FAIL b2b_last got=%h exp=%h", {hreadyout, hresp, hrdata}, eb);
        else n_pass++;
        mdl_hrdata = 32'h0000_00CC;
    endtask

    task automatic test_reset_mid_access();
        rec_t o, e;
        int   n;
        @(posedge hclk); #1; drive_addr(32'h4000_0400, 1'b1, 3'd2); hprot = 4'b0010;
        @(posedge hclk); #1; hsel = 0; htrans = 0; hwdata = 32'hBEEF_0001;
        n = 0;
        while (!(psel && penable) && n < 8) begin @(negedge hclk); n++; end
        @(negedge hclk);
        n_chk++;
        if (!(psel && penable)) $display("FAIL reset_mid_no_access psel=%b penable=%b exp=11", psel, penable);
        else n_pass++;
        hrst = 1; #1;
        mdl_hrdata = 32'h0;
        n_chk++;
        if ({psel, penable, hreadyout, hresp, hrdata, paddr, pwdata, pstrb, pwrite, pprot} !==
            {2'b00, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 3'h0})
            $display("FAIL reset_mid_access got=%h exp=%h",
                     {psel, penable, hreadyout, hresp, hrdata, paddr, pwdata, pstrb, pwrite, pprot},
                     {2'b00, 1'b1, 108'h0});
        else n_pass++;
        @(posedge hclk); #1; hrst = 0;
        sb.push_back(mk_exp(32'h4000_0600, 1'b1, 3'd1, 4'h1, 32'h0BAD_F00D, 0, 1'b0, 32'h0000_6666));
        xfer(32'h4000_0600, 1'b1, 3'd1, 4'h1, 32'h0BAD_F00D, 0, 1'b0, 32'h0000_6666, o);
        e = sb.pop_front();
        n_chk++;
        if (o !== e) $display("FAIL after_reset got=%h exp=%h", o, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_word_write();
        test_strobes();
        test_wait_read();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
